// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequencing controller for a 10-bit UART transmit shift register.
// Accepts a byte on a valid/ready handshake, builds an 8N1 frame
// {stop, data[7:0], start}, then pulses the register's load/shift enables at
// the baud rate. The register shifts in ones, so the line idles high.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   tx_valid  producer has a byte on tx_data
//   tx_data   byte to transmit (sampled only on the accept edge)
//   tx_ready  controller can accept a byte this cycle
//   tx_busy   a frame is loading or shifting
//   tx_done   one-cycle pulse coincident with the final shift
//   en_start  parallel-load enable to the shift register
//   en_shift  shift enable to the shift register
//   frame     parallel frame to the shift register, frame[0] sent first
module uart_tx_ctrl #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       en_start,
    output logic       en_shift,
    output logic [9:0] frame
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 10;

    localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(FRAME_W - 1);
    localparam logic [FRAME_W-1:0] FRAME_IDLE = '1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;

    // State and datapath registers; reset reloads an all-ones frame for INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            frame_q  <= FRAME_IDLE;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_cnt  <= bit_cnt_d;
            frame_q  <= frame_d;
        end
    end

    // Next-state, counter update and enable decode.
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_cnt_d  = bit_cnt;
        frame_d    = frame_q;
        tx_ready   = 1'b0;
        tx_busy    = 1'b0;
        tx_done    = 1'b0;
        en_start   = 1'b0;
        en_shift   = 1'b0;

        case (state)
            INIT: begin
                en_start = 1'b1;
                state_d  = IDLE;
            end
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    frame_d = {1'b1, tx_data, 1'b0};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                en_start   = 1'b1;
                tx_busy    = 1'b1;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = SEND;
            end
            SEND: begin
                tx_busy = 1'b1;
                if (baud_cnt == BAUD_LAST) begin
                    // Bit period ends: shift one bit out.
                    en_shift   = 1'b1;
                    baud_cnt_d = '0;
                    bit_cnt_d  = bit_cnt + BIT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        tx_done   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + CNT_W'(1);
                end
            end
            default: state_d = INIT;
        endcase

        // Reset holds every strobe low even though state sits in INIT.
        if (rst) begin
            tx_ready = 1'b0;
            tx_busy  = 1'b0;
            tx_done  = 1'b0;
            en_start = 1'b0;
            en_shift = 1'b0;
        end
    end

    assign frame = frame_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (BAUD_DIV=4 and 2), each driving a
// behavioural model of the 10-bit shift register. A scoreboard queue holds the
// expected frame per accepted byte and is checked against the serial line.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid = 1'b0, a_ready, a_busy, a_done, a_start, a_shift;
    logic [7:0] a_data = 8'h00;
    logic [9:0] a_frame;
    logic       b_valid = 1'b0, b_ready, b_busy, b_done, b_start, b_shift;
    logic [7:0] b_data = 8'h00;
    logic [9:0] b_frame;

    uart_tx_ctrl #(.BAUD_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(a_valid), .tx_data(a_data),
        .tx_ready(a_ready), .tx_busy(a_busy), .tx_done(a_done),
        .en_start(a_start), .en_shift(a_shift), .frame(a_frame)
    );

    uart_tx_ctrl #(.BAUD_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(b_valid), .tx_data(b_data),
        .tx_ready(b_ready), .tx_busy(b_busy), .tx_done(b_done),
        .en_start(b_start), .en_shift(b_shift), .frame(b_frame)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift register models; start at zero so the INIT load is observable.
    logic [9:0] sr_a = '0;
    logic [9:0] sr_b = '0;
    always @(posedge clk) begin
        if (a_start) sr_a <= a_frame;
        else if (a_shift) sr_a <= {1'b1, sr_a[9:1]};
        if (b_start) sr_b <= b_frame;
        else if (b_shift) sr_b <= {1'b1, sr_b[9:1]};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for dut_a.
    logic [9:0] exp_q[$];
    int nshift = 0, load_cyc = 0, last_cyc = 0;
    int shift_total = 0, done_total = 0, overlap = 0;
    logic [9:0] cap = '0;

    always @(negedge clk) begin
        if (rst) begin
            nshift = 0;
        end else begin
            if (a_start && a_shift) overlap++;
            if (a_done) done_total++;
            if (a_start && a_busy) begin
                load_cyc = cyc;
                nshift   = 0;
                chk("sb_load_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) chk("sb_load_frame", 32'(a_frame), 32'(exp_q[0]));
            end
            if (a_shift) begin
                shift_total++;
                chk("sb_bit_hold", cyc - ((nshift == 0) ? load_cyc : last_cyc), 4);
                last_cyc = cyc;
                cap[4'(nshift)] = sr_a[0];
                nshift++;
                chk("sb_done_on_shift", 32'(a_done), (nshift == 10) ? 1 : 0);
                if (nshift == 10) begin
                    chk("sb_frame_pending", exp_q.size(), 1);
                    if (exp_q.size() > 0) chk("sb_serial_frame", 32'(cap), 32'(exp_q.pop_front()));
                    nshift = 0;
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] d, output int acc);
        acc = -1;
        @(posedge clk); #1;
        a_valid = 1'b1;
        a_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_ready) begin
                acc = cyc;
                exp_q.push_back({1'b1, d, 1'b0});
                break;
            end
        end
        chk("accept_in_time", (acc >= 0) ? 1 : 0, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_data  = 8'($urandom);
    endtask

    task automatic wait_done_a(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_done) begin
                dc = cyc;
                break;
            end
        end
        chk("done_in_time", (dc >= 0) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        int         lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int acc, acc2, dc, st, d0, nbad, cnt;
        logic [19:0] got20, exp20;
        logic [9:0]  fb;

        vecs[0] = '{8'hA5, 10'h34A, 41};
        vecs[1] = '{8'h00, 10'h200, 41};
        vecs[2] = '{8'hFF, 10'h3FE, 41};
        vecs[3] = '{8'h3C, 10'h278, 41};

        // Reset and idle line
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_strobes_a", 32'({a_ready, a_busy, a_done, a_start, a_shift}), 0);
            chk("rst_strobes_b", 32'({b_ready, b_busy, b_done, b_start, b_shift}), 0);
            chk("rst_frame", 32'(a_frame), 32'h3FF);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("init_en_start", 32'(a_start), 1);
        chk("init_frame", 32'(a_frame), 32'h3FF);
        chk("init_not_ready", 32'(a_ready), 0);
        @(negedge clk);
        chk("idle_ready", 32'(a_ready), 1);
        nbad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sr_a[0] !== 1'b1 || sr_b[0] !== 1'b1) nbad++;
        end
        chk("idle_line_high", nbad, 0);

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            send_a(vecs[v].data, acc);
            @(negedge clk);
            chk("tbl_load_frame", 32'(a_frame), 32'(vecs[v].frame));
            chk("tbl_load_busy", 32'({a_busy, a_ready}), 32'h2);
            wait_done_a(dc);
            chk("tbl_done_latency", dc - acc, vecs[v].lat);
            @(negedge clk);
            chk("tbl_idle_after", 32'({a_ready, sr_a[0]}), 32'h3);
        end

        // Back-to-back with tx_valid held
        @(posedge clk); #1;
        a_valid = 1'b1;
        a_data  = 8'h00;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_ready) begin acc = cyc; exp_q.push_back(10'h200); break; end
        end
        @(posedge clk); #1;
        a_data = 8'hFF;
        st = shift_total;
        acc2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_ready) begin acc2 = cyc; exp_q.push_back(10'h3FE); break; end
        end
        chk("b2b_accept_gap", acc2 - acc, 42);
        @(posedge clk); #1;
        a_valid = 1'b0;
        wait_done_a(dc);
        chk("b2b_done_latency", dc - acc2, 41);
        @(negedge clk);
        chk("b2b_shift_count", shift_total - st, 20);

        // Busy ignore
        d0 = done_total;
        send_a(8'h12, acc);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        a_valid = 1'b1;
        a_data  = 8'h55;
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || a_frame !== 10'h224) nbad++;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("busy_ignore", nbad, 0);
        wait_done_a(dc);
        chk("busy_done_latency", dc - acc, 41);
        @(negedge clk);
        chk("busy_one_done", done_total - d0, 1);

        // Reset at the 5th shift
        send_a(8'hC3, acc);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_shift) begin
                cnt++;
                if (cnt == 5) break;
            end
        end
        chk("mid_reached_5th", cnt, 5);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_strobes", 32'({a_shift, a_busy, a_done}), 0);
        chk("mid_rst_frame", 32'(a_frame), 32'h3FF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_init_load", 32'({a_start, a_ready}), 32'h2);
        @(negedge clk);
        chk("mid_line_high", 32'({a_ready, sr_a[0]}), 32'h3);
        send_a(8'h3C, acc);
        @(negedge clk);
        chk("mid_new_frame", 32'(a_frame), 32'h278);
        wait_done_a(dc);
        chk("mid_new_latency", dc - acc, 41);

        // Minimum divider on dut_b
        @(posedge clk); #1;
        b_valid = 1'b1;
        b_data  = 8'h81;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_ready) begin acc = cyc; break; end
        end
        chk("min_accept_in_time", (acc >= 0) ? 1 : 0, 1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        b_data  = 8'h00;
        @(negedge clk);
        chk("min_load_frame", 32'(b_frame), 32'h302);
        fb = 10'h302;
        dc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got20[i] = sr_b[0];
            exp20[i] = fb[i / 2];
            if (b_done) dc = cyc;
        end
        chk("min_serial", 32'(got20), 32'(exp20));
        chk("min_done_latency", dc - acc, 21);

        chk("never_start_and_shift", overlap, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the 10-bit UART transmit shift register. It accepts a byte through a valid/ready handshake and builds the 10-bit frame: start bit, 8 data bits LSB first, stop bit. It then pulses the register's parallel-load and shift enables at the baud rate so the serial output produces one complete 8N1 frame. It sits between the transmit-side producer (CPU MMIO or test logic) and the shift register: `frame` drives the register's `Sw`, and `en_start` and `en_shift` drive the register's enables of the same names.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is 2 to 65535.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `tx_valid` in 1: producer has a byte on `tx_data`.
- `tx_data` in 8: byte to transmit.
- `tx_ready` out 1: controller can accept a byte this cycle.
- `tx_busy` out 1: a frame is loading or shifting.
- `tx_done` out 1: one-cycle pulse in the cycle of the final shift.
- `en_start` out 1: parallel-load enable to the shift register.
- `en_shift` out 1: shift enable to the shift register.
- `frame` out 10: parallel frame to the shift register. `frame[0]` is serialised first.

## Operation
- Registers:
  - `state` (INIT, IDLE, LOAD, SEND).
  - `baud_cnt`: 16 bits, counts 0..`BAUD_DIV`-1.
  - `bit_cnt`: 4 bits, counts 0..9.
  - `frame_q`: 10 bits, drives `frame`.
- Asynchronous reset: `state`=INIT, `baud_cnt`=0, `bit_cnt`=0, `frame_q`=10'h3FF. While `rst`=1, every 1-bit output is forced to 0.
- INIT (one cycle): `en_start`=1 with `frame`=10'h3FF, so the shift register fills with ones and the serial line idles high. Transitions to IDLE.
- IDLE: `tx_ready`=1.
  - An accept happens when `tx_valid`=1 and `tx_ready`=1.
  - On accept: `frame_q` <= {1'b1, `tx_data`, 1'b0}, and the state moves to LOAD.
  - Without `tx_valid`, the controller stays in IDLE.
- LOAD (one cycle): `en_start`=1, `tx_busy`=1. Clears both counters and transitions to SEND.
- SEND: `tx_busy`=1.
  - `baud_cnt` increments every cycle.
  - When `baud_cnt`=`BAUD_DIV`-1:
    - `en_shift`=1 for that cycle.
    - `baud_cnt` <= 0.
    - `bit_cnt` increments.
  - When this terminal cycle has `bit_cnt`=9, it is the 10th shift:
    - `tx_done`=1.
    - The state moves to IDLE.
- The 10th shift moves the line from the stop bit to idle high, because the register shifts in ones.
- Output decode:
  - `en_start` = INIT | LOAD.
  - `tx_ready` = IDLE.
  - `tx_busy` = LOAD | SEND.
  - `en_start` and `en_shift` are never asserted together.
- `tx_valid` and `tx_data` are ignored outside IDLE. `tx_data` is sampled only on the accept edge, so the producer may change it afterwards.
- Reset mid-frame aborts the frame immediately. After release, INIT reloads all ones, so the line is high from the first post-reset edge onward. No partial frame resumes.

## Timing
- Let cycle 0 be the accept cycle. Then:
  - Cycle 1 is LOAD.
  - The serial output equals the start bit (0) from cycle 2.
  - The k-th `en_shift` (k=1..10) occurs in cycle 1 + k·`BAUD_DIV`.
  - Each bit is held for exactly `BAUD_DIV` cycles.
- `tx_done` coincides with the 10th `en_shift`, in cycle 1 + 10·`BAUD_DIV`.
- IDLE resumes, with `tx_ready`=1, in cycle 2 + 10·`BAUD_DIV`.
- The minimum accept-to-accept interval is 10·`BAUD_DIV` + 2 cycles.
- After reset release: INIT occupies the first cycle, and `tx_ready` first rises in the second cycle.

## Test plan
- **Reset/idle.** Assert `rst` for 3 cycles, then release.
  - During reset: all 1-bit outputs are 0 and `frame`=10'h3FF.
  - First cycle after release: `en_start`=1.
  - Second cycle: `tx_ready`=1.
  - The serial output of the attached shift register stays 1 for 50 cycles.
- **Single frame.** `BAUD_DIV`=4, send `tx_data`=8'hA5.
  - `frame`=10'h34A.
  - Serial sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1, then idle 1.
  - `tx_done` occurs exactly 41 cycles after accept.
- **Back-to-back.** `BAUD_DIV`=4, hold `tx_valid` high with 8'h00 then 8'hFF.
  - The second accept occurs 42 cycles after the first.
  - No idle gap beyond one LOAD cycle.
  - Exactly 20 `en_shift` pulses across the two frames.
- **Busy ignore.** During a frame, pulse `tx_valid` with 8'h55.
  - No accept, `frame` unchanged, `tx_ready`=0 throughout.
  - Exactly one `tx_done`.
- **Reset mid-frame.** Assert `rst` at the 5th `en_shift`.
  - Immediately: `en_shift`/`tx_busy`/`tx_done`=0.
  - After release: INIT load, then the line reads 1.
  - A new byte 8'h3C transmits correctly.
- **Minimum divider.** `BAUD_DIV`=2, send 8'h81.
  - Each bit lasts 2 cycles.
  - `tx_done` is 21 cycles after accept.
